// File: rtl/ddr_phy_dqs_rdtrack.sv
// ddr_phy_dqs_rdtrack
//   Multi-lane DQS read-capture tracker (clk100m domain). Per lane it finds the
//   read preamble in the deserialized DQS stream. On detect it latches a one-hot
//   capture phase select and the read latency, then asserts rvalid for the
//   burst. Seamless back-to-back reads extend the burst. Reads that age out
//   with no preamble are counted as misses.
// Ports
//   clk100m  : sole clock
//   phy_rst  : asynchronous active-high reset
//   read     : read command issued this cycle
//   burst8   : 1 = BL8 (4 clk burst), 0 = BL4 (2 clk burst)
//   dqs_in   : lane n = [n*SER +: SER], higher bit index = earlier in time
//   cnt_clr  : synchronous clear of every miss_cnt
//   rsel     : per-lane one-hot capture select (SER+SER/2 bits per lane)
//   rvalid   : per-lane read data valid
//   rd_miss  : per-lane 1-cycle pulse when a read ages out with no preamble
//   miss_cnt : per-lane 8-bit saturating miss counter
//   rd_lat   : per-lane latency captured at the last detect
module ddr_phy_dqs_rdtrack #(
  parameter  int LANES  = 2,
  parameter  int SER    = 8,
  parameter  int RL_MIN = 8,
  parameter  int RL_MAX = 11,
  localparam int G      = SER / 2,
  localparam int RW     = SER + G,
  localparam int LW     = $clog2(RL_MAX + 2)
) (
  input  logic                  clk100m,
  input  logic                  phy_rst,
  input  logic                  read,
  input  logic                  burst8,
  input  logic [LANES*SER-1:0]  dqs_in,
  input  logic                  cnt_clr,
  output logic [LANES*RW-1:0]   rsel,
  output logic [LANES-1:0]      rvalid,
  output logic [LANES-1:0]      rd_miss,
  output logic [LANES*8-1:0]    miss_cnt,
  output logic [LANES*LW-1:0]   rd_lat
);

  typedef enum logic [1:0] {S_IDLE, S_DEFER, S_VALID} state_t;

  logic [RL_MAX:1]  r_read_sr;
  logic [2**LW-1:0] w_sr_ext;
  logic             w_any_rd;
  logic [LW-1:0]    w_lat;
  logic [1:0]       w_last_beat;

  always_ff @(posedge clk100m or posedge phy_rst) begin
    if (phy_rst) begin
      r_read_sr <= '0;
    end else begin
      r_read_sr[1] <= read;
      for (int unsigned j = 2; j <= RL_MAX; j++) r_read_sr[j] <= r_read_sr[j-1];
    end
  end

  // Zero-padded copy so a seamless probe at L+D beyond RL_MAX reads as "no read".
  always_comb begin
    w_sr_ext             = '0;
    w_sr_ext[RL_MAX:1]   = r_read_sr;
    w_lat                = '0;
    for (int unsigned j = RL_MIN; j <= RL_MAX; j++) begin
      if (r_read_sr[j]) w_lat = LW'(j);   // ascending scan: oldest pending read wins
    end
  end

  assign w_any_rd    = |r_read_sr[RL_MAX:RL_MIN];
  assign w_last_beat = burst8 ? 2'd3 : 2'd1;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [SER-1:0]   w_cur;
    logic [SER-1:0]   r_d1;
    logic [SER-1:0]   r_d2;
    logic [3*SER-1:0] w_win;
    logic [SER-1:0]   w_match;
    logic [SER-1:0]   w_oh;
    logic             w_defer;
    logic             w_detect;
    logic             w_miss;
    logic [RW-1:0]    w_rsel_d;
    logic [RW-1:0]    r_rsel;
    state_t           r_state;
    logic [1:0]       r_beat;
    logic [LW-1:0]    r_lat;
    logic             r_def;
    logic [7:0]       r_cnt;
    logic [LW-1:0]    w_seam_idx;

    assign w_cur = dqs_in[n*SER +: SER];
    assign w_win = {r_d2, r_d1, w_cur};

    // Preamble at phase k: G-1 highs, then two G-1 low groups, each group G apart.
    always_comb begin
      w_match = '0;
      w_oh    = '0;
      for (int unsigned k = 0; k < SER; k++) begin
        w_match[k] = (&w_win[k+2*SER -: G-1])
                   & ~(|w_win[k+2*SER-G -: G-1])
                   & ~(|w_win[k+2*SER-2*G -: G-1]);
        if (w_match[k]) begin
          w_oh    = '0;
          w_oh[k] = 1'b1;
        end
      end
    end

    // Upper-half phases land in the next word: capture one clock later.
    assign w_defer    = |w_oh[SER-1:G];
    assign w_rsel_d   = w_defer ? {{G{1'b0}}, w_oh[G-1:0], w_oh[SER-1:G]}
                                : {w_oh, {G{1'b0}}};
    assign w_detect   = (r_state == S_IDLE) && (|w_oh) && w_any_rd;
    assign w_miss     = (r_state == S_IDLE) && r_read_sr[RL_MAX] && !w_detect;
    assign w_seam_idx = r_lat + LW'(r_def);

    always_ff @(posedge clk100m or posedge phy_rst) begin
      if (phy_rst) begin
        r_d1    <= '0;
        r_d2    <= '0;
        r_rsel  <= '0;
        r_state <= S_IDLE;
        r_beat  <= '0;
        r_lat   <= '0;
        r_def   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_d1 <= w_cur;
        r_d2 <= r_d1;

        if (cnt_clr)                       r_cnt <= '0;
        else if (w_miss && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;

        case (r_state)
          S_IDLE: begin
            if (w_detect) begin
              r_rsel  <= w_rsel_d;
              r_lat   <= w_lat;
              r_def   <= w_defer;
              r_beat  <= '0;
              r_state <= w_defer ? S_DEFER : S_VALID;
            end
          end
          S_DEFER: begin
            r_beat  <= '0;
            r_state <= S_VALID;
          end
          S_VALID: begin
            if (r_beat == w_last_beat) begin
              r_beat <= '0;
              // A read issued exactly one burst after ours continues seamlessly.
              if (!w_sr_ext[w_seam_idx]) r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign rsel[n*RW +: RW]     = w_detect ? w_rsel_d : r_rsel;
    assign rvalid[n]            = (r_state == S_VALID);
    assign rd_miss[n]           = w_miss;
    assign miss_cnt[n*8 +: 8]   = r_cnt;
    assign rd_lat[n*LW +: LW]   = r_lat;
  end

endmodule

// File: tb/tb_ddr_phy_dqs_rdtrack.sv
module tb_ddr_phy_dqs_rdtrack;
  localparam int RL_MAX = 11;

  logic        clk100m = 1'b0;
  logic        phy_rst;
  logic        read;
  logic        burst8;
  logic [15:0] dqs_in;
  logic        cnt_clr;
  logic [23:0] rsel;
  logic [1:0]  rvalid;
  logic [1:0]  rd_miss;
  logic [15:0] miss_cnt;
  logic [7:0]  rd_lat;

  ddr_phy_dqs_rdtrack #(.LANES(2), .SER(8), .RL_MIN(8), .RL_MAX(11)) dut (
    .clk100m(clk100m), .phy_rst(phy_rst), .read(read), .burst8(burst8),
    .dqs_in(dqs_in), .cnt_clr(cnt_clr), .rsel(rsel), .rvalid(rvalid),
    .rd_miss(rd_miss), .miss_cnt(miss_cnt), .rd_lat(rd_lat)
  );

  always #5 clk100m = ~clk100m;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] s_rsel;
  logic [1:0]  s_rvalid, s_miss;
  logic [15:0] s_cnt;
  logic [7:0]  s_lat;
  bit          use_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Reads kept as issue timestamps; each burst is a [start,end] cycle window.
  int          m_cyc;
  int          m_reads[$];
  logic [7:0]  m_h1[2], m_h2[2];
  int          m_vs[2], m_ve[2], m_L[2], m_D[2], m_cnt[2];
  logic [11:0] m_rsel[2];

  function automatic void model_init();
    m_cyc = 0;
    m_reads.delete();
    for (int l = 0; l < 2; l++) begin
      m_h1[l] = 0; m_h2[l] = 0; m_vs[l] = 0; m_ve[l] = -1;
      m_L[l] = 0; m_D[l] = 0; m_cnt[l] = 0; m_rsel[l] = 0;
    end
  endfunction

  function automatic bit m_has(input int age);
    foreach (m_reads[i]) if (m_cyc - m_reads[i] == age) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [23:0] w;
    logic [7:0]  cur;
    logic [11:0] rs;
    int  khit, lmax, burst;
    bit  ok, idle, det, dfr, miss;
    burst = burst8 ? 4 : 2;
    while (m_reads.size() > 0 && m_cyc - m_reads[0] > RL_MAX) void'(m_reads.pop_front());
    lmax = -1;
    for (int a = 8; a <= RL_MAX; a++) if (m_has(a)) lmax = a;
    for (int l = 0; l < 2; l++) begin
      cur = dqs_in[l*8 +: 8];
      w = {m_h2[l], m_h1[l], cur};
      khit = -1;
      for (int k = 0; k < 8; k++) begin
        ok = 1;
        for (int b = 0; b < 3; b++) begin
          if (!w[k+16-b]) ok = 0;
          if (w[k+12-b])  ok = 0;
          if (w[k+8-b])   ok = 0;
        end
        if (ok) khit = k;
      end
      idle = (m_cyc > m_ve[l]);
      det  = idle && khit >= 0 && lmax >= 0;
      dfr  = khit >= 4;
      rs   = det ? (12'h1 << (dfr ? khit - 4 : khit + 4)) : m_rsel[l];
      miss = idle && m_has(RL_MAX) && !det;
      chk($sformatf("rnd_rsel%0d", l), s_rsel[l*12 +: 12], rs);
      chk($sformatf("rnd_rvalid%0d", l), s_rvalid[l], (m_cyc >= m_vs[l] && m_cyc <= m_ve[l]));
      chk($sformatf("rnd_miss%0d", l), s_miss[l], miss);
      chk($sformatf("rnd_cnt%0d", l), s_cnt[l*8 +: 8], m_cnt[l]);
      chk($sformatf("rnd_lat%0d", l), s_lat[l*4 +: 4], m_L[l]);
      if (det) begin
        m_rsel[l] = rs; m_L[l] = lmax; m_D[l] = dfr;
        m_vs[l] = m_cyc + 1 + dfr; m_ve[l] = m_vs[l] + burst - 1;
      end else if (m_cyc == m_ve[l] && m_L[l] + m_D[l] <= RL_MAX && m_has(m_L[l] + m_D[l])) begin
        m_ve[l] = m_ve[l] + burst;
      end
      if (cnt_clr) m_cnt[l] = 0;
      else if (miss && m_cnt[l] < 255) m_cnt[l]++;
      m_h2[l] = m_h1[l];
      m_h1[l] = cur;
    end
    if (read) m_reads.push_back(m_cyc);
    m_cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk100m);
    s_rsel = rsel; s_rvalid = rvalid; s_miss = rd_miss; s_cnt = miss_cnt; s_lat = rd_lat;
    if (use_model) model_step();
    @(posedge clk100m);
    #1;
  endtask

  task automatic cyc(input bit rd, input bit b8, input logic [7:0] d0, input logic [7:0] d1, input bit clr);
    read = rd; burst8 = b8; dqs_in = {d1, d0}; cnt_clr = clr;
    tick();
  endtask

  logic [7:0] wq0[$], wq1[$];

  function automatic void refill(input int l);
    logic [23:0] p;
    logic [7:0]  w[$];
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r < 4)       w.push_back(8'h00);
    else if (r == 4) w.push_back(8'($urandom));
    else begin
      p = 24'h7 << ($urandom_range(0, 7) + 14);
      w.push_back(p[23:16]); w.push_back(p[15:8]); w.push_back(p[7:0]);
    end
    foreach (w[i]) begin
      if (l == 0) wq0.push_back(w[i]);
      else        wq1.push_back(w[i]);
    end
  endfunction

  typedef struct {
    bit          rd;
    bit          b8;
    logic [7:0]  d0;
    logic [11:0] e_rsel0;
    logic [1:0]  e_rvalid;
    logic [1:0]  e_miss;
    logic [3:0]  e_lat0;
  } vec_t;
  vec_t tbl[32];

  int vcnt, vfirst, vlast, mcnt, mat;
  logic [7:0] w0, w1;

  initial begin
    // BL4 read k=2 detected at +9, then BL8 read k=6 deferred detect at +10.
    // Lane1 sees no preamble and misses each read at +11.
    for (int i = 0; i < 32; i++) begin
      tbl[i].rd       = (i == 0 || i == 14);
      tbl[i].b8       = (i >= 14);
      tbl[i].d0       = (i == 7) ? 8'h07 : (i == 22) ? 8'h70 : 8'h00;
      tbl[i].e_rsel0  = (i < 9) ? 12'h000 : (i < 24) ? 12'h040 : 12'h004;
      tbl[i].e_rvalid = (i == 10 || i == 11 || (i >= 26 && i <= 29)) ? 2'b01 : 2'b00;
      tbl[i].e_miss   = (i == 11 || i == 25) ? 2'b10 : 2'b00;
      tbl[i].e_lat0   = (i < 10) ? 4'd0 : (i < 25) ? 4'd9 : 4'd10;
    end

    phy_rst = 1; read = 0; burst8 = 0; dqs_in = '0; cnt_clr = 0;
    #2;
    chk("rst_rsel", rsel, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_miss", rd_miss, 0);
    chk("rst_cnt", miss_cnt, 0);
    chk("rst_lat", rd_lat, 0);
    @(posedge clk100m); #1;
    phy_rst = 0;

    for (int i = 0; i < 32; i++) begin
      cyc(tbl[i].rd, tbl[i].b8, tbl[i].d0, 8'h00, 0);
      chk($sformatf("tbl%0d_rsel0", i), s_rsel[11:0], tbl[i].e_rsel0);
      chk($sformatf("tbl%0d_rsel1", i), s_rsel[23:12], 0);
      chk($sformatf("tbl%0d_rvalid", i), s_rvalid, tbl[i].e_rvalid);
      chk($sformatf("tbl%0d_miss", i), s_miss, tbl[i].e_miss);
      chk($sformatf("tbl%0d_lat0", i), s_lat[3:0], tbl[i].e_lat0);
    end
    chk("tbl_misscnt", s_cnt, 16'h0200);

    // Seamless: two BL8 reads 4 cycles apart, lane0 k=1.
    vcnt = 0; vfirst = -1; vlast = -1; mcnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(i == 0 || i == 4, 1, (i == 7) ? 8'h03 : (i == 8) ? 8'h80 : 8'h00, 8'h00, 0);
      if (i == 9) chk("seam_rsel0", s_rsel[11:0], 12'h020);
      if (s_rvalid[0]) begin vcnt++; if (vfirst < 0) vfirst = i; vlast = i; end
      if (s_miss[0]) mcnt++;
    end
    chk("seam_vcnt", vcnt, 8);
    chk("seam_first", vfirst, 10);
    chk("seam_last", vlast, 17);
    chk("seam_miss0", mcnt, 0);
    chk("seam_lat0", s_lat[3:0], 9);

    // Misses, saturation, clear.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("clr_cnt", s_cnt, 0);
    mcnt = 0; mat = -1;
    for (int i = 0; i < 15; i++) begin
      cyc(i == 0, 0, 0, 0, 0);
      if (s_miss != 0) begin mcnt++; mat = i; if (s_miss != 2'b11) chk("miss_both", s_miss, 2'b11); end
    end
    chk("miss_pulses", mcnt, 1);
    chk("miss_at", mat, 11);
    chk("miss_cnt1", s_cnt, 16'h0101);
    for (int i = 0; i < 312; i++) cyc(i < 300, 0, 0, 0, 0);
    chk("miss_sat", s_cnt, 16'hFFFF);
    for (int i = 0; i < 14; i++) begin
      cyc(i == 0, 0, 0, 0, i == 11);
      if (i == 11) chk("clrwin_miss", s_miss, 2'b11);
      if (i == 12) chk("clrwin_cnt", s_cnt, 0);
    end

    // Two lanes, lane0 k=1, lane1 k=5 (deferred).
    for (int i = 0; i < 15; i++) begin
      cyc(i == 0, 0, (i == 7) ? 8'h03 : (i == 8) ? 8'h80 : 8'h00, (i == 7) ? 8'h38 : 8'h00, 0);
      if (i == 9)  chk("lanes_rsel", s_rsel, 24'h002020);
      if (i == 10) chk("lanes_rv10", s_rvalid, 2'b01);
      if (i == 11) chk("lanes_rv11", s_rvalid, 2'b11);
      if (i == 12) chk("lanes_rv12", s_rvalid, 2'b10);
      if (i == 13) chk("lanes_rv13", s_rvalid, 2'b00);
    end
    chk("lanes_lat", s_lat, 8'h99);

    // Async reset in the middle of a BL8 burst.
    for (int i = 0; i < 12; i++) cyc(i == 0, 1, (i == 7) ? 8'h07 : 8'h00, 0, 0);
    #2;
    chk("prerst_rvalid", rvalid, 2'b01);
    chk("prerst_rsel", rsel[11:0], 12'h040);
    phy_rst = 1;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rsel", rsel, 0);
    chk("midrst_lat", rd_lat, 0);
    @(posedge clk100m); #1;
    phy_rst = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(i == 0, 0, (i == 7) ? 8'h07 : 8'h00, 0, 0);
      if (i == 9)  chk("post_rsel0", s_rsel[11:0], 12'h040);
      if (i == 10) chk("post_rv10", s_rvalid, 2'b01);
      if (i == 12) chk("post_rv12", s_rvalid, 2'b00);
      if (i == 12) chk("post_lat", s_lat[3:0], 9);
    end

    // Randomized run against the reference model.
    phy_rst = 1;
    #1;
    @(posedge clk100m); #1;
    phy_rst = 0;
    model_init();
    use_model = 1;
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 250; i++) begin
        if (wq0.size() == 0) refill(0);
        if (wq1.size() == 0) refill(1);
        w0 = wq0.pop_front();
        w1 = wq1.pop_front();
        cyc((i < 230) && ($urandom_range(0, 4) == 0), seg % 2 == 1, w0, w1,
            $urandom_range(0, 63) == 0);
      end
    end
    use_model = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
